keypad_scan: RTL and testbench
==============================

# keypad_scan

Scanning 4x4 matrix-keypad input controller: the input-side counterpart to the multiplexed 7-segment display driver. It drives keypad rows one at a time and samples the columns through a synchronizer. Each key press is debounced into a 4-bit key code, which the CPU consumes over a valid/ready handshake. The block sits beside the display driver in the board top level.

## Interface
- SCAN_DIV, 1000: clk cycles per row slot; minimum 4.
- DEBOUNCE_CNT, 8: consecutive equal samples needed to accept a press or a release; minimum 2.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- col_in  input  4  keypad columns; active-low, pulled up, asynchronous to clk.
- row_out  output  4  row drive; active-low one-hot.
- key_code  output  4  accepted key, equal to 4*row + col.
- key_valid  output  1  key_code holds an unconsumed key.
- key_ready  input  1  consumer accepts the key when key_valid && key_ready.
- key_overrun  output  1  one-cycle pulse when an accepted key is dropped.

## Operation
- Columns pass through a 2-flop synchronizer, giving col_s = ~sync(col_in), active-high.
- Divider div_cnt counts 0..SCAN_DIV-1 and wraps. tick is asserted when div_cnt == SCAN_DIV-1. All sampling happens on tick only.
- row_idx (2 bits) selects the driven row: row_out = ~(4'b0001 << row_idx).
- States are SCAN, PRESS_DB, HELD and RELEASE_DB.
- SCAN:
  - On tick with col_s == 0: row_idx increments mod 4.
  - On tick with col_s != 0: cand_col becomes the lowest set bit index, cand_row becomes row_idx, db_cnt is set to 1, and the state goes to PRESS_DB.
  - row_idx does not advance while a press is detected.
- PRESS_DB: row_idx is frozen at cand_row.
  - On tick with col_s[cand_col] == 1: db_cnt increments. When db_cnt reaches DEBOUNCE_CNT, the block emits {cand_row, cand_col}, clears db_cnt and goes to HELD.
  - On tick with col_s[cand_col] == 0: row_idx increments, db_cnt clears and the state returns to SCAN.
- HELD: row frozen.
  - On tick with col_s[cand_col] == 0: db_cnt is set to 1 and the state goes to RELEASE_DB.
- RELEASE_DB:
  - On tick with col_s[cand_col] == 0: db_cnt increments. At DEBOUNCE_CNT, row_idx increments and the state goes to SCAN.
  - On tick with col_s[cand_col] == 1: db_cnt clears and the state returns to HELD. The key is not re-emitted.
- Other keys pressed during PRESS_DB, HELD or RELEASE_DB are ignored. There is no rollover.
- Emit behaviour:
  - key_valid == 0: key_code is loaded and key_valid is set.
  - key_valid == 1 and key_ready == 1 in the same cycle: the new code is loaded and key_valid stays 1.
  - key_valid == 1 and key_ready == 0: key_code is unchanged and key_overrun pulses.
- Handshake without emit: key_valid clears on the edge after key_valid && key_ready.
- key_code is stable while key_valid is high.

## Timing
- Reset values:
  - row_out = 4'b1110; key_code = 0; key_valid = 0; key_overrun = 0.
  - State is SCAN; div_cnt, row_idx and db_cnt are 0; synchronizer flops are 1 (columns idle).
- Reset mid-operation aborts any debounce and discards a pending key.
- Input to col_s latency is 2 cycles. Since SCAN_DIV >= 4, the columns have settled after a row switch before the sampling tick.
- Press latency: key_valid rises on the edge after the tick carrying the DEBOUNCE_CNT-th matching sample. This is DEBOUNCE_CNT-1 ticks after detection, or (DEBOUNCE_CNT-1)*SCAN_DIV cycles.
- key_overrun is high for exactly one cycle, coincident with the dropped emit edge.
- Bounce shorter than DEBOUNCE_CNT consecutive ticks never produces a key and never produces a second key.

## Structure
- Package keypad_pkg holds:
  - localparams ROWS = 4 and COLS = 4;
  - the typedef enum logic [1:0] kp_state_t {SCAN, PRESS_DB, HELD, RELEASE_DB};
  - the key-code width localparam KEY_W = 4.
- One sub-module, keypad_sync: a parameterized-width 2-flop synchronizer with async active-low reset to 1, used on col_in.
- Counter widths are $clog2(SCAN_DIV) and $clog2(DEBOUNCE_CNT+1).

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE_CNT = 3.
- Reset:
  - Stimulus: col_in = 4'hF, rst_n released.
  - Response: row_out cycles 1110, 1101, 1011, 0111, changing every 4 clocks; key_valid stays 0.
- Clean press:
  - Stimulus: col_in[2] low whenever row 1 is driven, held; key_ready = 1.
  - Response: key_code = 6, key_valid high for 1 cycle, exactly once.
  - Stimulus continued: release, then press again.
  - Response: a second key_code = 6.
- Bounce rejection:
  - Stimulus: press row 3 / col 0 for 2 ticks, then release for 1 tick, repeated.
  - Response: no key_valid.
  - Stimulus continued: press held for 3 ticks.
  - Response: key_code = 12.
- Release bounce:
  - Stimulus: after key 5 is accepted, open the column for 1 tick, then close it again.
  - Response: no second key; row_out stays frozen at 1101.
- Backpressure and overrun:
  - Stimulus: key_ready = 0; press keys 9, then 3.
  - Response: key_code stays 9 and key_overrun pulses once.
  - Stimulus continued: key_ready = 1 coincident with the emit of a third key F.
  - Response: key_code = F, key_valid stays high, no overrun.
- Async reset during PRESS_DB:
  - Stimulus: assert rst_n low during PRESS_DB.
  - Response: all outputs are at their reset values immediately; no key is emitted after release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// lowest_set picks the column reported when several columns are active at once.
package keypad_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int KEY_W = 4;

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} kp_state_t;

    // Lowest active column wins when several are pressed on the same row.
    function automatic logic [1:0] lowest_set(input logic [COLS-1:0] v);
        lowest_set = 2'd0;
        for (int i = COLS - 1; i >= 0; i--)
            if (v[i]) lowest_set = 2'(i);
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous inputs.
// Both stages reset to all-ones, which is the idle level of pulled-up columns.
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: one row driven at a time, press and release debounced on
// divider ticks, and each accepted key offered to the CPU over valid/ready.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COLS-1:0]  col_in,
    output logic [ROWS-1:0]  row_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);

    logic [COLS-1:0]  col_q;
    logic [COLS-1:0]  col_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    kp_state_t        state;
    logic [1:0]       row_idx;
    logic [1:0]       cand_row;
    logic [1:0]       cand_col;
    logic [DB_W-1:0]  db_cnt;
    logic             hit;
    logic             db_last;
    logic             emit;

    keypad_sync #(.W(COLS)) u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (col_in),
        .q     (col_q)
    );

    assign col_s   = ~col_q;
    assign tick    = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign row_out = ~(4'b0001 << row_idx);
    assign hit     = col_s[cand_col];
    // db_cnt is about to reach DEBOUNCE_CNT on this sample.
    assign db_last = (db_cnt == DB_W'(DEBOUNCE_CNT - 1));
    assign emit    = tick && (state == PRESS_DB) && hit && db_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // row_idx only moves in SCAN or when leaving a debounce, so it stays
    // equal to cand_row for the whole press/hold/release sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SCAN;
            row_idx  <= 2'd0;
            cand_row <= 2'd0;
            cand_col <= 2'd0;
            db_cnt   <= '0;
        end else if (tick) begin
            case (state)
                SCAN: begin
                    if (col_s != '0) begin
                        cand_col <= lowest_set(col_s);
                        cand_row <= row_idx;
                        db_cnt   <= DB_W'(1);
                        state    <= PRESS_DB;
                    end else begin
                        row_idx  <= row_idx + 2'd1;
                    end
                end
                PRESS_DB: begin
                    if (hit && db_last) begin
                        db_cnt  <= '0;
                        state   <= HELD;
                    end else if (hit) begin
                        db_cnt  <= db_cnt + 1'b1;
                    end else begin
                        row_idx <= row_idx + 2'd1;
                        db_cnt  <= '0;
                        state   <= SCAN;
                    end
                end
                HELD: begin
                    if (!hit) begin
                        db_cnt <= DB_W'(1);
                        state  <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (hit) begin
                        db_cnt  <= '0;
                        state   <= HELD;
                    end else if (db_last) begin
                        row_idx <= row_idx + 2'd1;
                        db_cnt  <= '0;
                        state   <= SCAN;
                    end else begin
                        db_cnt  <= db_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    // A new key may replace the held one only when the consumer takes the
    // old one on the same edge; otherwise the new key is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
        end else begin
            key_overrun <= 1'b0;
            if (emit) begin
                if (!key_valid || key_ready) begin
                    key_code  <= {cand_row, cand_col};
                    key_valid <= 1'b1;
                end else begin
                    key_overrun <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3 and a
// behavioural 4x4 key matrix; k = rising edges since reset release.
module tb_keypad_scan;

    logic        clk;
    logic        rst_n;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_overrun;
    logic [15:0] keys;

    int          checks = 0;
    int          failures = 0;
    int          acc_cnt = 0;
    int          vld_cyc = 0;
    int          ov_cnt = 0;
    logic [3:0]  last_code = 4'h0;
    int          acc_base;
    int          vld_base;
    int          ov_base;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .col_in      (col_in),
        .row_out     (row_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_overrun (key_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key r*4+c closed shorts column c to row r; a driven (low) row pulls it low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (key_valid) vld_cyc <= vld_cyc + 1;
            if (key_valid && key_ready) begin
                acc_cnt   <= acc_cnt + 1;
                last_code <= key_code;
            end
            if (key_overrun) ov_cnt <= ov_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        acc_base = acc_cnt;
        vld_base = vld_cyc;
        ov_base  = ov_cnt;
    endtask

    initial begin
        rst_n     = 1'b0;
        keys      = 16'h0;
        key_ready = 1'b1;

        // reset values and idle row rotation
        step(2);
        chk("rst_row", row_out, 4'b1110);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_ovr", key_overrun, 1'b0);
        rst_n = 1'b1;
        acc_base = acc_cnt;
        step(1);  chk("row_k1", row_out, 4'b1110);
        step(4);  chk("row_k5", row_out, 4'b1101);
        step(4);  chk("row_k9", row_out, 4'b1011);
        step(4);  chk("row_k13", row_out, 4'b0111);
        step(4);  chk("row_k17", row_out, 4'b1110);
        chk("idle_nokey", 16'(acc_cnt - acc_base), 16'd0);

        // clean press of key 6: detect at k=8, valid after k=16 for one cycle
        keys = 16'h0040;
        do_reset();
        step(15); chk("p6_k15_valid", key_valid, 1'b0);
        step(1);  chk("p6_k16_valid", key_valid, 1'b1);
        chk("p6_k16_code", key_code, 4'h6);
        step(1);  chk("p6_k17_valid", key_valid, 1'b0);
        step(43); chk("p6_held_once", 16'(acc_cnt - acc_base), 16'd1);
        keys = 16'h0;
        step(20);
        keys = 16'h0040;
        step(40);
        chk("p6_second", 16'(acc_cnt - acc_base), 16'd2);
        chk("p6_second_code", last_code, 4'h6);
        chk("p6_vld_cycles", 16'(vld_cyc - vld_base), 16'd2);

        // bounce on key 12: two ticks closed, one open, never three in a row
        keys = 16'h0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            keys = 16'h1000;
            step(8);
            keys = 16'h0;
            step(4);
        end
        chk("bnc_nokey", 16'(acc_cnt - acc_base), 16'd0);
        keys = 16'h1000;
        step(48);
        chk("bnc_held_key", 16'(acc_cnt - acc_base), 16'd1);
        chk("bnc_code", last_code, 4'hC);

        // release bounce on key 5: one open tick while held
        keys = 16'h0020;
        do_reset();
        step(24);
        chk("rb_first", 16'(acc_cnt - acc_base), 16'd1);
        chk("rb_code", last_code, 4'h5);
        keys = 16'h0;
        step(4);
        keys = 16'h0020;
        step(32);
        chk("rb_no_second", 16'(acc_cnt - acc_base), 16'd1);
        chk("rb_row_frozen", row_out, 4'b1101);

        // backpressure: 9 accepted at k=20, 3 dropped at k=48, F replaces at k=80
        key_ready = 1'b0;
        keys = 16'h0200;
        do_reset();
        step(20);
        chk("bp_k20_valid", key_valid, 1'b1);
        chk("bp_k20_code", key_code, 4'h9);
        keys = 16'h0008;
        step(27); chk("bp_k47_ovr", key_overrun, 1'b0);
        step(1);  chk("bp_k48_ovr", key_overrun, 1'b1);
        chk("bp_k48_code", key_code, 4'h9);
        keys = 16'h8000;
        step(1);  chk("bp_k49_ovr", key_overrun, 1'b0);
        step(30);
        chk("bp_k79_code", key_code, 4'h9);
        chk("bp_k79_valid", key_valid, 1'b1);
        chk("bp_ovr_once", 16'(ov_cnt - ov_base), 16'd1);
        key_ready = 1'b1;
        step(1);
        chk("bp_k80_code", key_code, 4'hF);
        chk("bp_k80_valid", key_valid, 1'b1);
        chk("bp_k80_ovr", key_overrun, 1'b0);

        // async reset during PRESS_DB of key 6 with F still pending
        key_ready = 1'b0;
        keys = 16'h0040;
        step(21);
        chk("ar_k101_row", row_out, 4'b1101);
        chk("ar_k101_code", key_code, 4'hF);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("ar_row", row_out, 4'b1110);
        chk("ar_code", key_code, 4'h0);
        chk("ar_valid", key_valid, 1'b0);
        chk("ar_ovr", key_overrun, 1'b0);
        keys = 16'h0;
        step(3);
        rst_n = 1'b1;
        acc_base = acc_cnt;
        key_ready = 1'b1;
        step(60);
        chk("ar_nokey", 16'(acc_cnt - acc_base), 16'd0);
        chk("ar_valid_after", key_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
